// File: rtl/key_pkg.sv
// Shared definitions for the push-button conditioning block: the per-key
// debounce state encoding and the helper that sizes the cycle counters.
package key_pkg;

  // Per-key debounce state, 2-bit encoding.
  typedef enum logic [1:0] {
    RELEASED    = 2'd0,
    CHK_PRESS   = 2'd1,
    HELD        = 2'd2,
    CHK_RELEASE = 2'd3
  } key_state_t;

  // Bits needed for a counter that must hold values 0..max_val.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) begin
      return 1;
    end else begin
      return $clog2(max_val + 1);
    end
  endfunction

endpackage

// File: rtl/key_debounce_one.sv
// Single-key conditioner: 2-flop synchroniser, debounce FSM and (when the
// build defines KEY_AUTOREPEAT_EN) the auto-repeat interval counter.
// Input key_in is already polarity-normalised: 1 = pressed.
// All outputs are registered; key_press and key_release are one-cycle pulses.
module key_debounce_one
  import key_pkg::*;
#(
  parameter int debounce_cycles      = 50000,
  parameter int repeat_delay_cycles  = 25000000,
  parameter int repeat_period_cycles = 5000000
) (
  input  logic clk,
  input  logic reset,
  input  logic key_in,
  output logic key_level,
  output logic key_press,
  output logic key_release
);

  localparam int               cnt_w   = cnt_width(debounce_cycles);
  localparam logic [cnt_w-1:0] cnt_max = cnt_w'(debounce_cycles);
  localparam logic [cnt_w-1:0] cnt_one = cnt_w'(1);

  logic             sync_meta;
  logic             sync_key;
  key_state_t       state;
  logic [cnt_w-1:0] cnt;

  // Every cycle count must be at least one; an illegal configuration leaves
  // this marker block in the elaborated hierarchy where it is easy to spot.
  if ((debounce_cycles < 1) || (repeat_delay_cycles < 1) ||
      (repeat_period_cycles < 1)) begin : g_illegal_cfg
  end

`ifdef KEY_AUTOREPEAT_EN
  localparam int rpt_span = (repeat_delay_cycles > repeat_period_cycles) ?
                            repeat_delay_cycles : repeat_period_cycles;
  localparam int               rpt_w      = cnt_width(rpt_span);
  localparam logic [rpt_w-1:0] rpt_delay  = rpt_w'(repeat_delay_cycles);
  localparam logic [rpt_w-1:0] rpt_period = rpt_w'(repeat_period_cycles);
  localparam logic [rpt_w-1:0] rpt_sat    = rpt_w'(rpt_span);
  localparam logic [rpt_w-1:0] rpt_one    = rpt_w'(1);

  // rpt_cnt holds the HELD cycles elapsed since the last press pulse; the
  // pulse fires on the cycle that brings it up to the current interval.
  logic [rpt_w-1:0] rpt_cnt;
  logic [rpt_w-1:0] rpt_next;
  logic [rpt_w-1:0] rpt_limit;
  logic             rpt_first;

  // Saturating next repeat count and the interval it is measured against.
  always_comb begin
    rpt_limit = rpt_period;
    if (rpt_first) begin
      rpt_limit = rpt_delay;
    end else begin
      rpt_limit = rpt_period;
    end
    if (rpt_cnt == rpt_sat) begin
      rpt_next = rpt_cnt;
    end else begin
      rpt_next = rpt_cnt + rpt_one;
    end
  end
`endif

  // Two-flop synchroniser; resets to the released level.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_meta <= 1'b0;
      sync_key  <= 1'b0;
    end else begin
      sync_meta <= key_in;
      sync_key  <= sync_meta;
    end
  end

  // Debounce FSM with registered level and one-cycle press/release pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RELEASED;
      cnt         <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
`ifdef KEY_AUTOREPEAT_EN
      rpt_cnt     <= '0;
      rpt_first   <= 1'b1;
`endif
    end else begin
      key_press   <= 1'b0;
      key_release <= 1'b0;
      case (state)
        RELEASED: begin
          if (sync_key) begin
            state <= CHK_PRESS;
            cnt   <= cnt_one;
          end else begin
            cnt   <= '0;
          end
        end
        CHK_PRESS: begin
          if (!sync_key) begin
            // Too short to be a press: drop it.
            state <= RELEASED;
            cnt   <= '0;
          end else if (cnt == cnt_max) begin
            state     <= HELD;
            cnt       <= '0;
            key_level <= 1'b1;
            key_press <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt   <= '0;
            rpt_first <= 1'b1;
`endif
          end else begin
            cnt <= (cnt < cnt_max) ? (cnt + cnt_one) : cnt;
          end
        end
        HELD: begin
          if (!sync_key) begin
            state <= CHK_RELEASE;
            cnt   <= cnt_one;
          end else begin
            cnt <= '0;
`ifdef KEY_AUTOREPEAT_EN
            if (rpt_next == rpt_limit) begin
              key_press <= 1'b1;
              rpt_cnt   <= '0;
              rpt_first <= 1'b0;
            end else begin
              rpt_cnt   <= rpt_next;
            end
`endif
          end
        end
        CHK_RELEASE: begin
          if (sync_key) begin
            // Release glitch: back to HELD, repeat timing resumes where it was.
            state <= HELD;
            cnt   <= '0;
          end else if (cnt == cnt_max) begin
            state       <= RELEASED;
            cnt         <= '0;
            key_level   <= 1'b0;
            key_release <= 1'b1;
`ifdef KEY_AUTOREPEAT_EN
            rpt_cnt     <= '0;
            rpt_first   <= 1'b1;
`endif
          end else begin
            cnt <= (cnt < cnt_max) ? (cnt + cnt_one) : cnt;
          end
        end
        default: begin
          state     <= RELEASED;
          cnt       <= '0;
          key_level <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/key_debounce_repeat.sv
// Push-button conditioner for the game top: per key, synchronise, debounce
// and turn the raw switch into a clean level plus press/release pulses.
// Optional auto-repeat press pulses are built when KEY_AUTOREPEAT_EN is
// defined (handled inside key_debounce_one).
module key_debounce_repeat #(
  parameter int n_keys               = 4,
  parameter int active_low           = 1,
  parameter int debounce_cycles      = 50000,
  parameter int repeat_delay_cycles  = 25000000,
  parameter int repeat_period_cycles = 5000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [n_keys-1:0] key_sw,
  output logic [n_keys-1:0] key_level,
  output logic [n_keys-1:0] key_press,
  output logic [n_keys-1:0] key_release
);

  logic [n_keys-1:0] key_norm;

  // Normalise polarity so that 1 always means pressed downstream.
  always_comb begin
    key_norm = key_sw;
    if (active_low != 0) begin
      key_norm = ~key_sw;
    end else begin
      key_norm = key_sw;
    end
  end

  for (genvar k = 0; k < n_keys; k++) begin : g_key
    key_debounce_one #(
      .debounce_cycles      (debounce_cycles),
      .repeat_delay_cycles  (repeat_delay_cycles),
      .repeat_period_cycles (repeat_period_cycles)
    ) u_key (
      .clk         (clk),
      .reset       (reset),
      .key_in      (key_norm[k]),
      .key_level   (key_level[k]),
      .key_press   (key_press[k]),
      .key_release (key_release[k])
    );
  end

endmodule

// File: tb/tb_key_debounce_repeat.sv
// Scoreboard bench for key_debounce_repeat (debounce 4, repeat 10/3, active-low).
// Stimulus pushes the expected pulse events; a negedge monitor pops and
// compares whenever the DUT shows a pulse, and flags missed events.
module tb_key_debounce_repeat;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] key_sw = 4'hF;
  logic [3:0] key_level, key_press, key_release;

  key_debounce_repeat #(
    .n_keys(4), .active_low(1), .debounce_cycles(4),
    .repeat_delay_cycles(10), .repeat_period_cycles(3)
  ) dut (
    .clk(clk), .reset(reset), .key_sw(key_sw),
    .key_level(key_level), .key_press(key_press), .key_release(key_release)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         at;
    logic [3:0] press;
    logic [3:0] rel;
    logic [3:0] level;
  } exp_t;

  exp_t sb[$];
  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  task automatic expect_ev(input int at, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l);
    exp_t e;
    e.at = at; e.press = p; e.rel = r; e.level = l;
    sb.push_back(e);
  endtask

  task automatic wait_to(input int target);
    while (cyc < target) @(negedge clk);
  endtask

  // Monitor: compare every pulse against the scoreboard head.
  always @(negedge clk) begin
    if (!reset) begin
      if (sb.size() > 0 && sb[0].at < cyc) begin
        check("missed_event", 32'(cyc), 32'(sb[0].at));
        void'(sb.pop_front());
      end
      if ((key_press | key_release) != 4'd0) begin
        if (sb.size() == 0) begin
          check("unexpected_pulse", {24'd0, key_press, key_release}, 32'd0);
        end else if (sb[0].at != cyc) begin
          check("pulse_cycle", 32'(cyc), 32'(sb[0].at));
        end else begin
          check("key_press", {28'd0, key_press}, {28'd0, sb[0].press});
          check("key_release", {28'd0, key_release}, {28'd0, sb[0].rel});
          check("key_level", {28'd0, key_level}, {28'd0, sb[0].level});
          void'(sb.pop_front());
        end
      end
    end
  end

  // Watchdog so the run can never hang.
  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached at cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    // Reset with all keys released (active-low high).
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_level", {28'd0, key_level}, 32'd0);
    check("rst_press", {28'd0, key_press}, 32'd0);
    check("rst_release", {28'd0, key_release}, 32'd0);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("idle_quiet", {24'd0, key_press, key_release}, 32'd0);
    end

    // Clean press and release of key 0.
    c = cyc;
    key_sw = 4'b1110;
    expect_ev(c + 7, 4'b0001, 4'b0000, 4'b0001);
    wait_to(c + 6);
    check("level_before_accept", {28'd0, key_level}, 32'd0);
    wait_to(c + 7);
    key_sw = 4'b1111;
    expect_ev(c + 14, 4'b0000, 4'b0001, 4'b0000);
    wait_to(c + 13);
    check("level_held", {28'd0, key_level}, 32'd1);
    wait_to(c + 15);
    check("level_after_release", {28'd0, key_level}, 32'd0);

    // 3-cycle press glitch on key 1: nothing reported.
    c = cyc;
    key_sw = 4'b1101;
    wait_to(c + 3);
    key_sw = 4'b1111;
    wait_to(c + 12);
    check("glitch_level", {28'd0, key_level}, 32'd0);

    // 3-cycle release glitch while key 0 is held: no release.
    c = cyc;
    key_sw = 4'b1110;
    expect_ev(c + 7, 4'b0001, 4'b0000, 4'b0001);
    wait_to(c + 7);
    key_sw = 4'b1111;
    wait_to(c + 10);
    key_sw = 4'b1110;
    wait_to(c + 13);
    check("held_glitch_level", {28'd0, key_level}, 32'd1);
    key_sw = 4'b1111;
    expect_ev(c + 20, 4'b0000, 4'b0001, 4'b0000);
    wait_to(c + 22);

    // All keys together.
    c = cyc;
    key_sw = 4'b0000;
    expect_ev(c + 7, 4'b1111, 4'b0000, 4'b1111);
    wait_to(c + 7);
    key_sw = 4'b1111;
    expect_ev(c + 14, 4'b0000, 4'b1111, 4'b0000);
    wait_to(c + 16);

    // Reset while key 2 is held, key stays held through reset.
    c = cyc;
    key_sw = 4'b1011;
    expect_ev(c + 7, 4'b0100, 4'b0000, 4'b0100);
    wait_to(c + 8);
    reset = 1'b1;
    wait_to(c + 9);
    reset = 1'b0;
    check("midrst_level", {28'd0, key_level}, 32'd0);
    check("midrst_pulses", {24'd0, key_press, key_release}, 32'd0);
    expect_ev(c + 16, 4'b0100, 4'b0000, 4'b0100);
    wait_to(c + 16);
    key_sw = 4'b1111;
    expect_ev(c + 23, 4'b0000, 4'b0100, 4'b0000);
    wait_to(c + 25);

    // Long hold of key 3: repeats at +10, +13, ... when enabled.
    c = cyc;
    key_sw = 4'b0111;
    expect_ev(c + 7, 4'b1000, 4'b0000, 4'b1000);
`ifdef KEY_AUTOREPEAT_EN
    for (int k = 17; k <= 29; k += 3) expect_ev(c + k, 4'b1000, 4'b0000, 4'b1000);
`endif
    wait_to(c + 29);
    key_sw = 4'b1111;
    expect_ev(c + 36, 4'b0000, 4'b1000, 4'b0000);
    wait_to(c + 40);

    check("scoreboard_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
